// File: rtl/branch_resolve_unit_if.sv
// Decode/fetch-side bundle for branch_resolve_unit: instruction, flags, jump LUT write port, PC and status.
// TakenCount is present only when BRANCH_COUNT_EN is defined.
interface branch_resolve_unit_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
);
    logic              Start;
    logic              Valid;
    logic              BrEn;
    logic [2:0]        Cond;
    logic [LUT_AW-1:0] TgtIdx;
    logic              Carry;
    logic              LessThan;
    logic              Zero;
    logic              AddFlag;
    logic              HaltReq;
    logic              LutWe;
    logic [LUT_AW-1:0] LutAddr;
    logic [PC_W-1:0]   LutData;
    logic [PC_W-1:0]   PC;
    logic              Taken;
    logic              Flush;
    logic              Running;
    logic              Done;
`ifdef BRANCH_COUNT_EN
    logic [15:0]       TakenCount;
`endif

    modport slave (
        input  Start, Valid, BrEn, Cond, TgtIdx,
        input  Carry, LessThan, Zero, AddFlag, HaltReq,
        input  LutWe, LutAddr, LutData,
`ifdef BRANCH_COUNT_EN
        output TakenCount,
`endif
        output PC, Taken, Flush, Running, Done
    );

    modport master (
        output Start, Valid, BrEn, Cond, TgtIdx,
        output Carry, LessThan, Zero, AddFlag, HaltReq,
        output LutWe, LutAddr, LutData,
`ifdef BRANCH_COUNT_EN
        input  TakenCount,
`endif
        input  PC, Taken, Flush, Running, Done
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolution and PC ownership: evaluates branch conditions on live flags, jumps through a writable LUT,
// and inserts one FLUSH bubble after each taken branch. Optional taken counter under BRANCH_COUNT_EN.
module branch_resolve_unit #(
    parameter int PC_W     = 10,
    parameter int LUT_AW   = 4,
    parameter int START_PC = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    branch_resolve_unit_if.slave  bus
);
    localparam int              LUT_N      = 1 << LUT_AW;
    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
    localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            start_acc;
    logic [PC_W-1:0] lut_q [LUT_N];

    function automatic logic cond_met_f(input logic [2:0] c, input logic cy, input logic lt,
                                        input logic z, input logic af);
        logic r;
        case (c)
            3'd0:    r = 1'b1;
            3'd1:    r = z;
            3'd2:    r = ~z;
            3'd3:    r = lt;
            3'd4:    r = ~lt;
            3'd5:    r = cy;
            3'd6:    r = ~cy;
            default: r = af;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        taken_d   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.Start) begin
                    state_d   = S_RUN;
                    pc_d      = START_PC_V;
                    start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.Valid) begin
                    // Halt has priority over any branch decoded in the same cycle.
                    if (bus.HaltReq) begin
                        state_d = S_HALT;
                    end else if (bus.BrEn && cond_met_f(bus.Cond, bus.Carry, bus.LessThan,
                                                        bus.Zero, bus.AddFlag)) begin
                        pc_d    = lut_q[bus.TgtIdx];
                        taken_d = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    // Branch read above sees the pre-write entry when the same index is written this cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
        end else if (bus.LutWe) begin
            lut_q[bus.LutAddr] <= bus.LutData;
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else if (taken_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.TakenCount = cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

    assign bus.PC      = pc_q;
    assign bus.Taken   = taken_q;
    assign bus.Flush   = (state_q == S_FLUSH);
    assign bus.Running = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.Done    = (state_q == S_HALT);
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the flags path: samples registered Carry/LessThan/Zero/AddFlag, evaluates the branch condition of the current instruction and owns the program counter.
- Sits between instruction decode and instruction fetch.
- Target addresses come from an internal, writable jump LUT indexed by the instruction's target field.
- A single-bubble FLUSH state follows every taken branch.

Parameters:
- PC_W, 10, program counter / target address width.
- LUT_AW, 4, jump LUT index width (2**LUT_AW entries).
- START_PC, 0, PC value loaded on Start.

Ports:
- Clk  in  1  clock, all state on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin execution at START_PC.
- Valid  in  1  decoded instruction valid this cycle.
- BrEn  in  1  instruction is a conditional/unconditional branch.
- Cond  in  3  condition select.
- TgtIdx  in  LUT_AW  jump LUT index.
- Carry, LessThan, Zero, AddFlag  in  1 each  flags from flags register.
- HaltReq  in  1  halt instruction decoded.
- LutWe  in  1  LUT write enable.
- LutAddr  in  LUT_AW  LUT write index.
- LutData  in  PC_W  LUT write data.
- PC  out  PC_W  current fetch address (registered).
- Taken  out  1  one-cycle pulse, branch taken.
- Flush  out  1  high in FLUSH state; fetch/decode discard.
- Running  out  1  high in RUN or FLUSH.
- Done  out  1  high in HALT.
- TakenCount  out  16  taken-branch counter (only with BRANCH_COUNT_EN).

Behaviour:
- Reset low, asynchronous: state=IDLE; PC=0; Taken=Flush=Done=0; Running=0; all LUT entries=0; TakenCount=0. Reset mid-operation aborts immediately; a pending branch is lost.
- States: IDLE, RUN, FLUSH, HALT.
- IDLE:
  - Start=1 -> RUN, PC<=START_PC next edge.
  - All other inputs except the LUT write port are ignored.
- RUN, Valid=0: PC holds.
- RUN, Valid=1, HaltReq=1: -> HALT, PC holds. Halt wins over a simultaneous branch; Taken stays 0.
- RUN, Valid=1, BrEn=1: cond evaluated combinationally from the current flag inputs.
  - Cond codes: 0 always, 1 Zero, 2 !Zero, 3 LessThan, 4 !LessThan, 5 Carry, 6 !Carry, 7 AddFlag.
  - Taken: PC<=LUT[TgtIdx]; Taken=1 for the following cycle; -> FLUSH.
  - Not taken: PC<=PC+1.
- RUN, Valid=1, BrEn=0: PC<=PC+1.
- PC arithmetic: modulo 2**PC_W; PC=2**PC_W-1 increments to 0.
- FLUSH:
  - Lasts exactly one cycle; Flush=1; PC holds the target; Valid/BrEn/HaltReq ignored; -> RUN.
  - Reset is the only exit other than RUN.
- HALT: Done=1; PC holds; Start=1 -> RUN with PC<=START_PC.
- Output timing: Taken, Flush, Running, Done are registered (decoded from state/flops), no combinational input-to-output paths.
- LUT:
  - Write synchronous, any state.
  - Read combinational.
  - Write and branch read to the same index in the same cycle: branch uses the old value.
- Flags are consumed as presented in the evaluating cycle; no internal flag capture.

Optional Feature:
- Macro BRANCH_COUNT_EN.
- Defined: TakenCount port exists; 16-bit counter increments on every taken branch (the cycle Taken asserts), saturates at 16'hFFFF, cleared by reset and by Start.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low mid-RUN with PC=0x05 -> PC=0 and all outputs 0 immediately (no clock edge needed); IDLE after release.
- Start; 3 non-branch Valid cycles -> PC 0,1,2,3; Running=1, Taken=0.
- LUT[2]=0x1A0; branch Cond=1, Zero=1, TgtIdx=2 at PC=0x003 -> next PC=0x1A0, Taken pulse 1 cycle, Flush 1 cycle, Valid ignored during Flush, then PC=0x1A1.
- Same branch with Zero=0 -> PC=0x004, Taken=0, no Flush; repeat for Cond 2-7 with each flag set/clear.
- HaltReq=1 with taken branch same cycle -> HALT, Done=1, PC unchanged; Start -> PC=START_PC, Running=1.
- PC=0x3FF non-branch -> PC=0x000. LUT write LUT[2]=0x055 in same cycle as branch via idx 2 (old 0x1A0) -> PC=0x1A0. With BRANCH_COUNT_EN: 3 taken branches -> TakenCount=3.
